// File: rtl/multi_deque_pkg.sv
// Shared encodings for the multi-channel deque: end selection and command decode.
package multi_deque_pkg;

    localparam logic END_FRONT = 1'b0;
    localparam logic END_BACK  = 1'b1;

    typedef enum logic [1:0] {
        OP_NOP     = 2'd0,
        OP_PUSH    = 2'd1,
        OP_POP     = 2'd2,
        OP_REPLACE = 2'd3
    } op_e;

    // push and pop in the same cycle collapse into a single replace
    function automatic op_e decode_op(input logic push, input logic pop);
        case ({push, pop})
            2'b10:   return OP_PUSH;
            2'b01:   return OP_POP;
            2'b11:   return OP_REPLACE;
            default: return OP_NOP;
        endcase
    endfunction

endpackage

// File: rtl/multi_deque_if.sv
// Command / data bus of the multi-channel deque.
interface multi_deque_if #(
    parameter int WIDTH    = 8,
    parameter int CHANNELS = 2
) ();
    localparam int CH_BITS = $clog2(CHANNELS);

    logic [CH_BITS-1:0]  ch_sel;
    logic                end_sel;
    logic                push;
    logic                pop;
    logic [WIDTH-1:0]    data_in;
    logic [WIDTH-1:0]    data_out;
    logic                data_valid;
    logic [CHANNELS-1:0] empty;
    logic [CHANNELS-1:0] full;
    logic                error;

    modport master (
        output ch_sel, end_sel, push, pop, data_in,
        input  data_out, data_valid, empty, full, error
    );

    modport slave (
        input  ch_sel, end_sel, push, pop, data_in,
        output data_out, data_valid, empty, full, error
    );
endinterface

// File: rtl/multi_deque_channel.sv
// One double-ended queue: circular buffer with head/tail pointers and occupancy count.
module deque_channel
    import multi_deque_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int DEPTH = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             i_en,
    input  op_e              i_op,
    input  logic             i_end,
    input  logic [WIDTH-1:0] i_data,
    output logic [WIDTH-1:0] o_rd_data,
    output logic             o_empty,
    output logic             o_full,
    output logic             o_op_err
);
    localparam int PTR_W    = $clog2(DEPTH);
    localparam int CNT_BITS = $clog2(DEPTH) + 1;

    logic [WIDTH-1:0]    r_mem [DEPTH];
    logic [PTR_W-1:0]    r_head;
    logic [PTR_W-1:0]    r_tail;
    logic [CNT_BITS-1:0] r_count;

    logic [PTR_W-1:0]    w_head_m1;
    logic [PTR_W-1:0]    w_tail_m1;
    logic [PTR_W-1:0]    w_end_addr;
    logic [WIDTH-1:0]    w_end_data;
    logic                w_front;
    logic                w_do_push;
    logic                w_do_pop;
    logic                w_do_repl;
    logic                w_we;
    logic [PTR_W-1:0]    w_waddr;

    assign o_empty    = (r_count == '0);
    assign o_full     = (r_count == CNT_BITS'(DEPTH));
    assign w_front    = (i_end == END_FRONT);
    assign w_head_m1  = r_head - PTR_W'(1);
    assign w_tail_m1  = r_tail - PTR_W'(1);
    // the element currently sitting at the selected end
    assign w_end_addr = w_front ? r_head : w_tail_m1;
    assign w_end_data = r_mem[w_end_addr];

    assign w_do_push  = i_en && (i_op == OP_PUSH)    && !o_full;
    assign w_do_pop   = i_en && (i_op == OP_POP)     && !o_empty;
    assign w_do_repl  = i_en && (i_op == OP_REPLACE) && !o_empty;
    assign o_op_err   = i_en && (((i_op == OP_PUSH) && o_full) || ((i_op == OP_POP) && o_empty));

    // select the storage write slot for a push or an in-place replace
    always_comb begin
        w_we    = 1'b0;
        w_waddr = r_tail;
        if (w_do_push) begin
            w_we    = 1'b1;
            w_waddr = w_front ? w_head_m1 : r_tail;
        end else if (w_do_repl) begin
            w_we    = 1'b1;
            w_waddr = w_end_addr;
        end
    end

    // read word for the top to register; replace on an empty channel passes data_in through
    always_comb begin
        o_rd_data = '0;
        if (i_en) begin
            if (i_op == OP_REPLACE)
                o_rd_data = o_empty ? i_data : w_end_data;
            else if (w_do_pop)
                o_rd_data = w_end_data;
        end
    end

    // storage write; contents are deliberately not reset
    always_ff @(posedge clk) begin
        if (w_we)
            r_mem[w_waddr] <= i_data;
    end

    // pointer and occupancy update
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_head  <= '0;
            r_tail  <= '0;
            r_count <= '0;
        end else if (w_do_push) begin
            if (w_front) r_head <= w_head_m1;
            else         r_tail <= r_tail + PTR_W'(1);
            r_count <= r_count + CNT_BITS'(1);
        end else if (w_do_pop) begin
            if (w_front) r_head <= r_head + PTR_W'(1);
            else         r_tail <= w_tail_m1;
            r_count <= r_count - CNT_BITS'(1);
        end
    end
endmodule

// File: rtl/multi_deque.sv
// CHANNELS independent deques behind one shared command/data bus with registered read data.
module multi_deque
    import multi_deque_pkg::*;
#(
    parameter int WIDTH    = 8,
    parameter int DEPTH    = 16,
    parameter int CHANNELS = 2
) (
    input  logic          clk,
    input  logic          rst,
    multi_deque_if.slave  bus
);
    localparam int CH_BITS  = $clog2(CHANNELS);
    localparam int CNT_BITS = $clog2(DEPTH) + 1;

    op_e                 w_op;
    logic                w_cmd;
    logic                w_ch_ok;
    logic [CHANNELS-1:0] w_en;
    logic [CHANNELS-1:0] w_empty;
    logic [CHANNELS-1:0] w_full;
    logic [CHANNELS-1:0] w_op_err;
    logic [WIDTH-1:0]    w_rd_data [CHANNELS];
    logic [WIDTH-1:0]    w_rd_or;
    logic                w_vld_nxt;
    logic                w_err_nxt;

    logic [WIDTH-1:0]    r_data_out;
    logic                r_data_valid;
    logic                r_error;

    assign w_op    = decode_op(bus.push, bus.pop);
    assign w_cmd   = bus.push || bus.pop;
    assign w_ch_ok = (32'(bus.ch_sel) < 32'(CHANNELS));

    for (genvar g = 0; g < CHANNELS; g++) begin : g_ch
        assign w_en[g] = w_ch_ok && (bus.ch_sel == CH_BITS'(g));

        deque_channel #(
            .WIDTH (WIDTH),
            .DEPTH (DEPTH)
        ) u_ch (
            .clk       (clk),
            .rst       (rst),
            .i_en      (w_en[g]),
            .i_op      (w_op),
            .i_end     (bus.end_sel),
            .i_data    (bus.data_in),
            .o_rd_data (w_rd_data[g]),
            .o_empty   (w_empty[g]),
            .o_full    (w_full[g]),
            .o_op_err  (w_op_err[g])
        );
    end

    // merge channel read data (unselected channels drive zero) and derive next strobes
    always_comb begin
        w_rd_or   = '0;
        w_vld_nxt = 1'b0;
        for (int i = 0; i < CHANNELS; i++) begin
            w_rd_or   = w_rd_or | w_rd_data[i];
            w_vld_nxt = w_vld_nxt ||
                        (w_en[i] && ((w_op == OP_REPLACE) || ((w_op == OP_POP) && !w_empty[i])));
        end
        w_err_nxt = (|w_op_err) || (w_cmd && !w_ch_ok);
    end

    // registered read data, valid strobe and error pulse
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_data_out   <= '0;
            r_data_valid <= 1'b0;
            r_error      <= 1'b0;
        end else begin
            r_data_out   <= w_vld_nxt ? w_rd_or : '0;
            r_data_valid <= w_vld_nxt;
            r_error      <= w_err_nxt;
        end
    end

    assign bus.data_out   = r_data_out;
    assign bus.data_valid = r_data_valid;
    assign bus.error      = r_error;
    assign bus.empty      = w_empty;
    assign bus.full       = w_full;

    // occupancy width is fixed by DEPTH; keep it visible for integrators
    localparam int CNT_W_EXPORT = CNT_BITS;
endmodule

// File: tb/tb_multi_deque.sv
// Directed bench for multi_deque: vector table plus hand sequences for fill, wrap and async reset.
module tb_multi_deque;
    import multi_deque_pkg::*;

    localparam int WIDTH    = 8;
    localparam int DEPTH    = 16;
    localparam int CHANNELS = 2;

    logic clk;
    logic rst;

    multi_deque_if #(.WIDTH(WIDTH), .CHANNELS(CHANNELS)) bus ();

    multi_deque #(
        .WIDTH    (WIDTH),
        .DEPTH    (DEPTH),
        .CHANNELS (CHANNELS)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic       ch;
        logic       e;
        logic       push;
        logic       pop;
        logic [7:0] din;
        logic       x_vld;
        logic [7:0] x_dout;
        logic       x_err;
        logic [1:0] x_empty;
        logic [1:0] x_full;
    } vec_t;

    int n_tests = 0;
    int n_fail  = 0;
    vec_t vt [$];
    logic [7:0] model_q [$];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // drive one command at the falling edge, check outputs just after the next rising edge
    task automatic run(input vec_t v, input string name);
        @(negedge clk);
        bus.ch_sel  = v.ch;
        bus.end_sel = v.e;
        bus.push    = v.push;
        bus.pop     = v.pop;
        bus.data_in = v.din;
        @(posedge clk);
        #1;
        chk({name, ".valid"}, 32'(bus.data_valid), 32'(v.x_vld));
        chk({name, ".dout"},  32'(bus.data_out),   32'(v.x_dout));
        chk({name, ".err"},   32'(bus.error),      32'(v.x_err));
        chk({name, ".empty"}, 32'(bus.empty),      32'(v.x_empty));
        chk({name, ".full"},  32'(bus.full),       32'(v.x_full));
    endtask

    function automatic vec_t mk(logic ch, logic e, logic pu, logic po, logic [7:0] d,
                                logic xv, logic [7:0] xd, logic xe, logic [1:0] xem, logic [1:0] xf);
        vec_t v;
        v.ch = ch; v.e = e; v.push = pu; v.pop = po; v.din = d;
        v.x_vld = xv; v.x_dout = xd; v.x_err = xe; v.x_empty = xem; v.x_full = xf;
        return v;
    endfunction

    initial begin
        bus.ch_sel = '0; bus.end_sel = 1'b0; bus.push = 1'b0; bus.pop = 1'b0; bus.data_in = '0;
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        chk("rst.empty", 32'(bus.empty), 32'h3);
        chk("rst.full",  32'(bus.full),  32'h0);
        chk("rst.dout",  32'(bus.data_out), 32'h0);
        chk("rst.valid", 32'(bus.data_valid), 32'h0);
        chk("rst.err",   32'(bus.error), 32'h0);
        @(negedge clk);
        rst = 1'b0;

        // ch, end, push, pop, din | valid, dout, err, empty, full
        vt.push_back(mk(0, END_BACK,  1, 0, 8'h11, 0, 8'h00, 0, 2'b10, 2'b00));
        vt.push_back(mk(0, END_BACK,  1, 0, 8'h22, 0, 8'h00, 0, 2'b10, 2'b00));
        vt.push_back(mk(0, END_BACK,  1, 0, 8'h33, 0, 8'h00, 0, 2'b10, 2'b00));
        vt.push_back(mk(0, END_FRONT, 0, 1, 8'h00, 1, 8'h11, 0, 2'b10, 2'b00));
        vt.push_back(mk(0, END_FRONT, 0, 1, 8'h00, 1, 8'h22, 0, 2'b10, 2'b00));
        vt.push_back(mk(0, END_FRONT, 0, 1, 8'h00, 1, 8'h33, 0, 2'b11, 2'b00));
        vt.push_back(mk(0, END_FRONT, 0, 0, 8'h00, 0, 8'h00, 0, 2'b11, 2'b00));
        vt.push_back(mk(1, END_FRONT, 1, 0, 8'hA0, 0, 8'h00, 0, 2'b01, 2'b00));
        vt.push_back(mk(1, END_FRONT, 1, 0, 8'hA1, 0, 8'h00, 0, 2'b01, 2'b00));
        vt.push_back(mk(1, END_FRONT, 0, 1, 8'h00, 1, 8'hA1, 0, 2'b01, 2'b00));
        vt.push_back(mk(1, END_BACK,  0, 1, 8'h00, 1, 8'hA0, 0, 2'b11, 2'b00));
        vt.push_back(mk(1, END_FRONT, 0, 1, 8'h00, 0, 8'h00, 1, 2'b11, 2'b00));
        vt.push_back(mk(1, END_FRONT, 0, 0, 8'h00, 0, 8'h00, 0, 2'b11, 2'b00));
        vt.push_back(mk(1, END_BACK,  1, 1, 8'h5A, 1, 8'h5A, 0, 2'b11, 2'b00));
        vt.push_back(mk(1, END_BACK,  0, 0, 8'h00, 0, 8'h00, 0, 2'b11, 2'b00));
        foreach (vt[i]) run(vt[i], $sformatf("vec%0d", i));

        // fill ch0 with 0x00..0x0F
        for (int i = 0; i < DEPTH; i++) begin
            run(mk(0, END_BACK, 1, 0, 8'(i), 0, 8'h00, 0, 2'b10, (i == DEPTH-1) ? 2'b01 : 2'b00),
                $sformatf("fill%0d", i));
            model_q.push_back(8'(i));
        end
        run(mk(0, END_BACK,  1, 0, 8'hFF, 0, 8'h00, 1, 2'b10, 2'b01), "ovf");
        run(mk(0, END_BACK,  1, 1, 8'h77, 1, 8'h0F, 0, 2'b10, 2'b01), "repl_full");
        model_q[$] = 8'h77;
        run(mk(0, END_BACK,  0, 1, 8'h00, 1, 8'h77, 0, 2'b10, 2'b00), "pop_after_repl");
        void'(model_q.pop_back());

        // steady-state push back / pop front to wrap the pointers several times
        for (int k = 0; k < 40; k++) begin
            logic [7:0] w;
            w = 8'h80 + 8'(k);
            run(mk(0, END_BACK, 1, 0, w, 0, 8'h00, 0, 2'b10, 2'b01), $sformatf("wrap_push%0d", k));
            model_q.push_back(w);
            run(mk(0, END_FRONT, 0, 1, 8'h00, 1, model_q[0], 0, 2'b10, 2'b00), $sformatf("wrap_pop%0d", k));
            void'(model_q.pop_front());
        end
        run(mk(0, END_BACK, 1, 0, 8'hC3, 0, 8'h00, 0, 2'b10, 2'b01), "refill");

        // three pushes on ch1, a pop in flight, then asynchronous reset between edges
        run(mk(1, END_BACK,  1, 0, 8'h01, 0, 8'h00, 0, 2'b00, 2'b01), "pre_rst0");
        run(mk(1, END_BACK,  1, 0, 8'h02, 0, 8'h00, 0, 2'b00, 2'b01), "pre_rst1");
        run(mk(1, END_BACK,  1, 0, 8'h03, 0, 8'h00, 0, 2'b00, 2'b01), "pre_rst2");
        run(mk(1, END_FRONT, 0, 1, 8'h00, 1, 8'h01, 0, 2'b00, 2'b01), "pre_rst_pop");
        #2;
        rst = 1'b1;
        #1;
        chk("arst.empty", 32'(bus.empty), 32'h3);
        chk("arst.full",  32'(bus.full),  32'h0);
        chk("arst.valid", 32'(bus.data_valid), 32'h0);
        chk("arst.dout",  32'(bus.data_out), 32'h0);
        @(negedge clk);
        rst = 1'b0;
        run(mk(0, END_FRONT, 0, 1, 8'h00, 0, 8'h00, 1, 2'b11, 2'b00), "post_rst_pop");
        run(mk(0, END_FRONT, 0, 0, 8'h00, 0, 8'h00, 0, 2'b11, 2'b00), "post_rst_idle");

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    // watchdog in case the stimulus thread stalls
    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "timeout");
    end
endmodule
